// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter that time-shares the hex display path between NREQ requesters.
// Each grant latches one requester's value for DWELL cycles, followed by an optional BLANK gap.
module hex_display_arbiter #(
    parameter int NREQ  = 4,
    parameter int W     = 10,
    parameter int DWELL = 50000000,
    parameter int BLANK = 5000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*W-1:0]       req_data,
    input  logic                    hold,
    output logic [NREQ-1:0]         grant,
    output logic [W-1:0]            disp_value,
    output logic [$clog2(NREQ)-1:0] disp_src,
    output logic                    disp_on
);
    localparam int SRC_W   = $clog2(NREQ);
    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

    typedef enum logic [1:0] {ARB, SHOW, GAP} state_t;

    state_t           state_q, state_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [W-1:0]     disp_value_q, disp_value_d;
    logic [SRC_W-1:0] disp_src_q, disp_src_d;
    logic             disp_on_q, disp_on_d;

    logic [W-1:0] slice [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign slice[g] = req_data[g*W +: W];
    end

    logic             sel_found;
    logic [SRC_W-1:0] sel_idx;
    logic [SRC_W-1:0] sel_next;

    // Scan from the farthest offset down so the requester closest to ptr wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_next  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[SRC_W'((int'(ptr_q) + k) % NREQ)]) begin
                sel_found = 1'b1;
                sel_idx   = SRC_W'((int'(ptr_q) + k) % NREQ);
                sel_next  = SRC_W'((int'(ptr_q) + k + 1) % NREQ);
            end
        end
    end

    // NOTE: combinational next-state logic uses blocking '=' with every output
    // defaulted first, so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        grant_d      = '0;
        disp_value_d = disp_value_q;
        disp_src_d   = disp_src_q;
        disp_on_d    = disp_on_q;

        case (state_q)
            ARB: begin
                disp_on_d = 1'b0;
                if (sel_found) begin
                    disp_value_d     = slice[sel_idx];
                    disp_src_d       = sel_idx;
                    grant_d[sel_idx] = 1'b1;
                    disp_on_d        = 1'b1;
                    cnt_d            = DWELL_LOAD;
                    ptr_d            = sel_next;
                    state_d          = SHOW;
                end
            end
            SHOW: begin
                if (!hold) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        disp_on_d = 1'b0;
                        if (BLANK > 0) begin
                            cnt_d   = BLANK_LOAD;
                            state_d = GAP;
                        end else begin
                            state_d = ARB;
                        end
                    end
                end
            end
            GAP: begin
                disp_on_d = 1'b0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ARB;
                end
            end
            default: begin
                state_d   = ARB;
                disp_on_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples the
    // pre-edge values computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB;
            ptr_q        <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            disp_value_q <= '0;
            disp_src_q   <= '0;
            disp_on_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            disp_value_q <= disp_value_d;
            disp_src_q   <= disp_src_d;
            disp_on_q    <= disp_on_d;
        end
    end

    assign grant      = grant_q;
    assign disp_value = disp_value_q;
    assign disp_src   = disp_src_q;
    assign disp_on    = disp_on_q;
endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter (NREQ=4, W=10, DWELL=4, BLANK=2).
// Expected grants are queued when stimulus is applied and popped when the DUT grants.
module tb_hex_display_arbiter;
    localparam int NREQ  = 4;
    localparam int W     = 10;
    localparam int DWELL = 4;
    localparam int BLANK = 2;

    typedef struct {
        logic [NREQ-1:0] g;
        logic [W-1:0]    v;
        logic [1:0]      s;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] req_data = '0;
    logic              hold = 1'b0;
    logic [NREQ-1:0]   grant;
    logic [W-1:0]      disp_value;
    logic [1:0]        disp_src;
    logic              disp_on;

    exp_t       sb[$];
    logic [W-1:0] shown = '0;
    int         n_checks = 0;
    int         n_errors = 0;

    hex_display_arbiter #(
        .NREQ(NREQ), .W(W), .DWELL(DWELL), .BLANK(BLANK)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .hold(hold),
        .grant(grant), .disp_value(disp_value), .disp_src(disp_src), .disp_on(disp_on)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [NREQ-1:0] g, input logic [W-1:0] v, input logic [1:0] s);
        exp_t e;
        e.g = g;
        e.v = v;
        e.s = s;
        sb.push_back(e);
    endtask

    task automatic set_slice(input int i, input logic [W-1:0] v);
        req_data[i*W +: W] = v;
    endtask

    // Waits (bounded) for the next grant, checks the wait length and the latched outputs.
    task automatic expect_grant(input int exp_wait, input string tag);
        int   waits;
        exp_t e;
        waits = 0;
        while (grant === '0 && waits < 30) begin
            check({tag, "_off"}, 32'(disp_on), 32'd0);
            tick();
            waits++;
        end
        check({tag, "_wait"}, 32'(waits), 32'(exp_wait));
        check({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_grant"}, 32'(grant), 32'(e.g));
            check({tag, "_value"}, 32'(disp_value), 32'(e.v));
            check({tag, "_src"}, 32'(disp_src), 32'(e.s));
            check({tag, "_on"}, 32'(disp_on), 32'd1);
            shown = e.v;
        end
    endtask

    // Counts cycles with disp_on high from the current sample, checking grant and value.
    task automatic measure_show(input string tag, output int on_cycles);
        on_cycles = 0;
        while (disp_on === 1'b1 && on_cycles < 100) begin
            if (on_cycles > 0) check({tag, "_gnt_lo"}, 32'(grant), 32'd0);
            check({tag, "_stable"}, 32'(disp_value), 32'(shown));
            on_cycles++;
            tick();
        end
    endtask

    task automatic drain(input string tag);
        repeat (2) begin
            tick();
            check({tag, "_drain_gnt"}, 32'(grant), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int on;
        int idle_bad;

        // Reset
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_value", 32'(disp_value), 32'd0);
        check("rst_src", 32'(disp_src), 32'd0);
        check("rst_on", 32'(disp_on), 32'd0);
        rst = 1'b0;

        // Single requester, re-grant picks up fresh data
        req = 4'b0001;
        set_slice(0, 10'h155);
        push(4'b0001, 10'h155, 2'd0);
        expect_grant(1, "single");
        set_slice(0, 10'h0AA);
        push(4'b0001, 10'h0AA, 2'd0);
        measure_show("single", on);
        check("single_dwell", 32'(on), 32'd4);
        expect_grant(3, "regrant");
        req = 4'b0000;

        // Asynchronous reset two cycles into SHOW
        tick();
        #3 rst = 1'b1;
        #1;
        check("arst_on", 32'(disp_on), 32'd0);
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_value", 32'(disp_value), 32'd0);
        tick();
        rst = 1'b0;

        // Round robin over all four requesters
        set_slice(0, 10'h001);
        set_slice(1, 10'h102);
        set_slice(2, 10'h203);
        set_slice(3, 10'h304);
        req = 4'b1111;
        push(4'b0001, 10'h001, 2'd0);
        push(4'b0010, 10'h102, 2'd1);
        push(4'b0100, 10'h203, 2'd2);
        push(4'b1000, 10'h304, 2'd3);
        push(4'b0001, 10'h001, 2'd0);
        expect_grant(1, "rr0");
        for (int i = 1; i < 5; i++) begin
            measure_show("rr", on);
            check("rr_dwell", 32'(on), 32'd4);
            expect_grant(3, $sformatf("rr%0d", i));
        end

        // Requester 2 drops its request mid-show
        req = 4'b0110;
        set_slice(1, 10'h111);
        set_slice(2, 10'h3FF);
        push(4'b0010, 10'h111, 2'd1);
        push(4'b0100, 10'h3FF, 2'd2);
        measure_show("rr_last", on);
        expect_grant(3, "drop_r1");
        measure_show("drop_r1", on);
        expect_grant(3, "drop_r2");
        req = 4'b0010;
        set_slice(2, 10'h000);
        push(4'b0010, 10'h111, 2'd1);
        measure_show("drop_r2", on);
        check("drop_dwell", 32'(on), 32'd4);
        expect_grant(3, "drop_next");

        // Hold for 10 cycles starting at SHOW cycle 2
        push(4'b0010, 10'h111, 2'd1);
        tick();
        hold = 1'b1;
        repeat (9) begin
            tick();
            check("hold_on", 32'(disp_on), 32'd1);
        end
        tick();
        hold = 1'b0;
        measure_show("hold", on);
        check("hold_dwell", 32'(11 + on), 32'd14);
        expect_grant(3, "hold_gap");
        req = 4'b0000;
        measure_show("hold_tail", on);
        drain("hold_tail");

        // Idle, then a late request
        idle_bad = 0;
        repeat (100) begin
            tick();
            if (grant !== '0 || disp_on !== 1'b0) idle_bad++;
        end
        check("idle_quiet", 32'(idle_bad), 32'd0);
        req = 4'b1000;
        set_slice(3, 10'h2A5);
        push(4'b1000, 10'h2A5, 2'd3);
        expect_grant(1, "late");
        req = 4'b0000;
        measure_show("late", on);
        check("late_dwell", 32'(on), 32'd4);

        check("sb_final", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
